// File: rtl/multi_edge_pulser.sv
// multi_edge_pulser
//   Multi-channel edge-to-pulse converter for push-buttons and slow asynchronous
//   inputs. Each channel synchronises its raw input, debounces it, and emits a
//   one-cycle pulse when the debounced level changes in the direction chosen by
//   edge_sel.
//
// Parameters
//   N_CH            number of independent channels
//   SYNC_STAGES     flops per synchroniser chain (>= 2)
//   DEBOUNCE_CYCLES consecutive cycles the synced level must differ before it is accepted (>= 1)
//   REPEAT_DELAY    auto-repeat: cycles from the press pulse to the first repeat
//   REPEAT_PERIOD   auto-repeat: cycles between later repeats
//
// Build option
//   AUTO_REPEAT_EN  when defined, a held channel (level_out=1, edge_sel 00 or 10)
//                   produces extra repeat pulses. When undefined no repeat logic
//                   exists and REPEAT_* only feed the parameter sanity checks.
//
// Ports
//   clk        in   1     system clock, rising edge
//   rst        in   1     synchronous active-high reset
//   din        in   N_CH  raw asynchronous inputs
//   edge_sel   in   2     00 rising, 01 falling, 10 both, 11 disabled
//   level_out  out  N_CH  debounced level per channel
//   pulse_out  out  N_CH  registered one-cycle event pulse per channel
//   any_pulse  out  1     registered OR of pulse_out
module multi_edge_pulser #(
  parameter int unsigned N_CH            = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 8,
  parameter int unsigned REPEAT_PERIOD   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] din,
  input  logic [1:0]      edge_sel,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] pulse_out,
  output logic            any_pulse
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("multi_edge_pulser: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("multi_edge_pulser: DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("multi_edge_pulser: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_mode_t;

  localparam int unsigned          CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  edge_mode_t      mode;
  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] s;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [N_CH-1:0] accept;
  logic [N_CH-1:0] level_d;
  logic [N_CH-1:0] edge_pulse;
  logic [N_CH-1:0] rep_fire;
  logic [N_CH-1:0] pulse_d;

  always_comb mode = edge_mode_t'(edge_sel);
  always_comb s = sync_q[SYNC_STAGES-1];

  // Synchroniser: din feeds the first flop directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= din;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Debounce and edge qualification.
  always_comb begin
    accept     = '0;
    level_d    = level_out;
    edge_pulse = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      cnt_d[i] = '0;
      if (s[i] != level_out[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          accept[i]  = 1'b1;
          level_d[i] = s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
      case (mode)
        EDGE_RISE: edge_pulse[i] = accept[i] & s[i];
        EDGE_FALL: edge_pulse[i] = accept[i] & ~s[i];
        EDGE_BOTH: edge_pulse[i] = accept[i];
        default:   edge_pulse[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned      REP_MAX      = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned      REP_W        = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DLY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PER_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt_q [N_CH];
  logic [REP_W-1:0] rep_cnt_d [N_CH];
  logic [N_CH-1:0]  rep_first_q;
  logic [N_CH-1:0]  rep_first_d;
  logic             rep_mode_ok;

  // The counter restarts on any accepted edge, so it begins counting on the
  // cycle after the press pulse; rep_first selects the initial delay versus the
  // steady repeat period.
  always_comb begin
    rep_mode_ok = (mode == EDGE_RISE) || (mode == EDGE_BOTH);
    rep_fire    = '0;
    rep_first_d = rep_first_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      rep_cnt_d[i] = '0;
      if (!level_out[i] || !rep_mode_ok || accept[i]) begin
        rep_first_d[i] = 1'b1;
      end else if (rep_cnt_q[i] == (rep_first_q[i] ? REP_DLY_LAST : REP_PER_LAST)) begin
        rep_fire[i]    = 1'b1;
        rep_first_d[i] = 1'b0;
      end else begin
        rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_first_q <= '1;
      for (int unsigned i = 0; i < N_CH; i++) rep_cnt_q[i] <= '0;
    end else begin
      rep_first_q <= rep_first_d;
      for (int unsigned i = 0; i < N_CH; i++) rep_cnt_q[i] <= rep_cnt_d[i];
    end
  end
`else
  always_comb rep_fire = '0;
`endif

  always_comb pulse_d = edge_pulse | rep_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      level_out <= '0;
      pulse_out <= '0;
      any_pulse <= 1'b0;
    end else begin
      level_out <= level_d;
      pulse_out <= pulse_d;
      any_pulse <= |pulse_d;
    end
  end

endmodule
